// File: rtl/arp_server_deadlock_reporter.sv
// Filters the ARP server deadlock-monitor block signal, latches a sticky deadlock flag and emits
// one report record per declaration. Optional timestamping: define ARP_DEADLOCK_TIMESTAMP_EN.
module arp_server_deadlock_reporter #(
    parameter int THRESHOLD_W = 16,
    parameter int EVT_W       = 8,
    parameter int TS_W        = 48
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   block,
    input  logic [THRESHOLD_W-1:0] threshold,
    input  logic                   clear,
    output logic                   deadlock,
    output logic [THRESHOLD_W-1:0] run_cnt,
    output logic [EVT_W-1:0]       event_cnt,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [EVT_W-1:0]       rpt_event,
    output logic [TS_W-1:0]        rpt_timestamp,
    output logic                   rpt_ovf
);

    // state   | meaning
    // IDLE    | block low, run counter at zero
    // COUNT   | block high, counting consecutive cycles toward threshold
    // HOLD    | deadlock declared, block still high
    // LATCHED | block released, flag held until clear
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        HOLD    = 2'd2,
        LATCHED = 2'd3
    } state_t;

    state_t                 state;
    logic [THRESHOLD_W-1:0] thr_eff;
    logic [THRESHOLD_W:0]   run_inc;
    logic [THRESHOLD_W-1:0] run_next;
    logic                   armed;
    logic                   declare;
    logic                   accept;
    logic [TS_W-1:0]        ts_now;

    assign thr_eff  = (threshold == '0) ? THRESHOLD_W'(1) : threshold;
    assign run_inc  = {1'b0, run_cnt} + (THRESHOLD_W + 1)'(1);
    assign run_next = run_inc[THRESHOLD_W] ? '1 : run_inc[THRESHOLD_W-1:0];
    assign armed    = (state == IDLE) || (state == COUNT);
    // Compare on the unsaturated sum so a saturated count still meets an all-ones threshold.
    assign declare  = armed && block && (run_inc >= {1'b0, thr_eff});
    assign accept   = rpt_valid && rpt_ready;

`ifdef ARP_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign ts_now = ts_cnt;
`else
    assign ts_now = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            deadlock <= 1'b0;
            run_cnt  <= '0;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    run_cnt <= block ? run_next : '0;
                    if (declare) begin
                        state    <= HOLD;
                        deadlock <= 1'b1;
                    end else if (block) begin
                        state <= COUNT;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (clear) begin
                        state    <= IDLE;
                        deadlock <= 1'b0;
                        run_cnt  <= '0;
                    end else if (!block) begin
                        state <= LATCHED;
                    end
                end
                LATCHED: begin
                    if (clear) begin
                        state    <= IDLE;
                        deadlock <= 1'b0;
                        run_cnt  <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    deadlock <= 1'b0;
                    run_cnt  <= '0;
                end
            endcase
        end
    end

    // Report slot: a new declaration may load only if the slot is empty or retiring this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            event_cnt     <= '0;
            rpt_valid     <= 1'b0;
            rpt_event     <= '0;
            rpt_timestamp <= '0;
            rpt_ovf       <= 1'b0;
        end else begin
            if (declare) begin
                if (event_cnt != '1) begin
                    event_cnt <= event_cnt + EVT_W'(1);
                end
                if (!rpt_valid || rpt_ready) begin
                    rpt_valid     <= 1'b1;
                    rpt_event     <= event_cnt;
                    rpt_timestamp <= ts_now;
                end else begin
                    rpt_ovf <= 1'b1;
                end
            end else if (accept) begin
                rpt_valid <= 1'b0;
            end
        end
    end

endmodule
